// File: rtl/jk_sync_tx.sv
// J/K line transmitter: sends sync KJKJKJKK, NRZI bit-stuffed data LSB first, then SE0,SE0,J EOP.
// One-byte holding buffer in front of an 8-bit shift register, fed over a valid/ready handshake.
module jk_sync_tx #(
  parameter int unsigned BIT_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       out_j,
  output logic       out_k,
  output logic       out_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    EOP0  = 3'd4,
    EOP1  = 3'd5,
    EOP2  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [2:0]    ones, ones_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    buf_data, buf_data_nxt;
  logic          buf_full, buf_full_nxt;
  logic          buf_last, buf_last_nxt;
  logic          cur_last, cur_last_nxt;
  logic          j_nxt, k_nxt, en_nxt, done_nxt, err_nxt, ready_nxt, busy_nxt;
  logic          accept, bit_end, reload, send_data, toggle, go_eop;
  logic [7:0]    src;

  // Next-state, datapath and line decisions; line changes only at bit period boundaries.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    bit_cnt_nxt  = bit_cnt;
    ones_nxt     = ones;
    shreg_nxt    = shreg;
    buf_data_nxt = buf_data;
    buf_full_nxt = buf_full;
    buf_last_nxt = buf_last;
    cur_last_nxt = cur_last;
    j_nxt        = out_j;
    k_nxt        = out_k;
    en_nxt       = out_en;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    reload       = 1'b0;
    send_data    = 1'b0;
    toggle       = 1'b0;
    go_eop       = 1'b0;
    src          = shreg;
    accept       = tx_valid & tx_ready;
    bit_end      = (timer == T_MAX);

    if (state != IDLE) begin
      timer_nxt = bit_end ? '0 : timer + TW'(1);
    end

    case (state)
      IDLE: begin
        if (buf_full) begin
          state_nxt = SYNC;
          reload    = 1'b1;
          timer_nxt = '0;
          ones_nxt  = '0;
          en_nxt    = 1'b1;
          toggle    = 1'b1;
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            send_data   = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            toggle      = (bit_cnt != 3'd6);
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (ones == 3'd6) begin
            state_nxt = STUFF;
            ones_nxt  = '0;
            toggle    = 1'b1;
          end else if (bit_cnt == 3'd7) begin
            go_eop = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            send_data   = 1'b1;
          end
        end
      end
      STUFF: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            go_eop = 1'b1;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = bit_cnt + 3'd1;
            send_data   = 1'b1;
          end
        end
      end
      EOP0: begin
        if (bit_end) state_nxt = EOP1;
      end
      EOP1: begin
        if (bit_end) begin
          state_nxt = EOP2;
          j_nxt     = 1'b1;
          k_nxt     = 1'b0;
        end
      end
      EOP2: begin
        if (bit_end) begin
          state_nxt = IDLE;
          en_nxt    = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Byte boundary: finish the packet, chain the buffered byte, or flag an underrun.
    if (go_eop) begin
      if (cur_last) begin
        state_nxt = EOP0;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
      end else if (buf_full) begin
        state_nxt = DATA;
        reload    = 1'b1;
        send_data = 1'b1;
      end else begin
        state_nxt = EOP0;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        err_nxt   = 1'b1;
      end
    end

    if (reload) begin
      src          = buf_data;
      shreg_nxt    = buf_data;
      cur_last_nxt = buf_last;
      buf_full_nxt = 1'b0;
      bit_cnt_nxt  = '0;
    end

    // NRZI: a 0 toggles the line, a 1 holds it and feeds the stuffing counter.
    if (send_data) begin
      shreg_nxt = {1'b0, src[7:1]};
      if (src[0]) begin
        ones_nxt = ones + 3'd1;
      end else begin
        ones_nxt = '0;
        toggle   = 1'b1;
      end
    end

    if (toggle) begin
      j_nxt = ~out_j;
      k_nxt = ~out_k;
    end

    if (accept) begin
      buf_data_nxt = tx_data;
      buf_last_nxt = tx_last;
      buf_full_nxt = 1'b1;
    end

    ready_nxt = ~buf_full_nxt & ~(state_nxt inside {EOP0, EOP1, EOP2});
    busy_nxt  = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      ones     <= '0;
      shreg    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      buf_last <= 1'b0;
      cur_last <= 1'b0;
      out_j    <= 1'b1;
      out_k    <= 1'b0;
      out_en   <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ones     <= ones_nxt;
      shreg    <= shreg_nxt;
      buf_data <= buf_data_nxt;
      buf_full <= buf_full_nxt;
      buf_last <= buf_last_nxt;
      cur_last <= cur_last_nxt;
      out_j    <= j_nxt;
      out_k    <= k_nxt;
      out_en   <= en_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
      tx_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jk_sync_tx.sv
// Directed bench for jk_sync_tx: packet vectors with hand-encoded line symbols (J, K, S=SE0) per bit period.
module tb_jk_sync_tx;

  localparam int unsigned D = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, out_j, out_k, out_en, tx_busy, tx_done, tx_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  jk_sync_tx #(.BIT_DIV(D)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .out_j    (out_j),
    .out_k    (out_k),
    .out_en   (out_en),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  typedef struct {
    string      name;
    logic [7:0] b0;
    logic [7:0] b1;
    int         nb;
    logic       lastf;
    string      exp;
    int         exp_err;
    int         rdy_per;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sym(input logic j, input logic k);
    case ({j, k})
      2'b10:   return 8'h4A;  // J
      2'b01:   return 8'h4B;  // K
      2'b00:   return 8'h53;  // S
      default: return 8'h58;  // X
    endcase
  endfunction

  task automatic chk_idle(input string p);
    chk({p, "_j"},     32'(out_j),    32'd1);
    chk({p, "_k"},     32'(out_k),    32'd0);
    chk({p, "_en"},    32'(out_en),   32'd0);
    chk({p, "_ready"}, 32'(tx_ready), 32'd1);
    chk({p, "_busy"},  32'(tx_busy),  32'd0);
  endtask

  // Offers the packet bytes, then samples every clock from the first sync bit until after EOP.
  task automatic run_pkt(input vec_t v);
    int   sent, c, len, en_cnt, done_cnt, err_cnt, both_cnt;
    logic started, acc, finished;
    logic [7:0] e;
    sent = 0; c = -1; en_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    started = 1'b0; finished = 1'b0;
    len = v.exp.len();
    tx_valid = 1'b1;
    tx_data  = v.b0;
    tx_last  = (v.nb == 1) && v.lastf;
    for (int n = 0; n < len * int'(D) + 64; n++) begin
      acc = tx_valid && tx_ready;
      @(posedge CLK); #1;
      if (c >= 0) c++;
      else if (started) c = 0;
      if (acc) begin
        sent++;
        if (sent == 1) started = 1'b1;
        if (sent < v.nb) begin
          tx_data = v.b1;
          tx_last = v.lastf && (sent == v.nb - 1);
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (c >= 0) begin
        if (c < len * int'(D)) begin
          if (out_en) en_cnt++;
          if (out_j && out_k) both_cnt++;
          if ((c % int'(D)) == int'(D / 2)) begin
            e = v.exp[c / int'(D)];
            chk($sformatf("%s_bit%0d", v.name, c / int'(D)), 32'(sym(out_j, out_k)), 32'(e));
          end
        end else if (out_en) begin
          en_cnt++;
        end
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (v.rdy_per > 0 && c == v.rdy_per * int'(D) - 1)
          chk({v.name, "_ready_before"}, 32'(tx_ready), 32'd0);
        if (v.rdy_per > 0 && c == v.rdy_per * int'(D))
          chk({v.name, "_ready_rise"}, 32'(tx_ready), 32'd1);
        if (c == len * int'(D) + 1) begin
          finished = 1'b1;
          break;
        end
      end
    end
    tx_valid = 1'b0;
    chk({v.name, "_timeout"}, 32'(finished), 32'd1);
    chk({v.name, "_sent"},    32'(sent),     32'(v.nb));
    chk({v.name, "_en_clks"}, 32'(en_cnt),   32'(len * int'(D)));
    chk({v.name, "_done"},    32'(done_cnt), 32'd1);
    chk({v.name, "_err"},     32'(err_cnt),  32'(v.exp_err));
    chk({v.name, "_jk11"},    32'(both_cnt), 32'd0);
    chk_idle({v.name, "_end"});
  endtask

  initial begin
    vecs[0] = '{"a5",    8'hA5, 8'h00, 1, 1'b1, "KJKJKJKKKJJKJJKKSSJ", 0, -1};
    vecs[1] = '{"ff",    8'hFF, 8'h00, 1, 1'b1, "KJKJKJKKKKKKKKJJJSSJ", 0, -1};
    vecs[2] = '{"two",   8'h00, 8'h3C, 2, 1'b1, "KJKJKJKKJKJKJKJKJKKKKKJKSSJ", 0, 16};
    vecs[3] = '{"under", 8'h12, 8'h00, 1, 1'b0, "KJKJKJKKJJKJJKJKSSJ", 1, -1};

    // Reset held with a byte offered: nothing may be accepted.
    RST = 1'b0; tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("rst");
    tx_valid = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_noacc_busy", 32'(tx_busy), 32'd0);
    chk("rst_noacc_en",   32'(out_en),  32'd0);

    for (int i = 0; i < 4; i++) begin
      run_pkt(vecs[i]);
      repeat (2) @(posedge CLK);
      #1;
    end

    // Reset in the middle of the data phase, then a clean packet.
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b1;
    @(posedge CLK); #1;
    tx_valid = 1'b0;
    repeat (12 * D) @(posedge CLK);
    #1;
    chk("mid_en",   32'(out_en),  32'd1);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk_idle("midrst");
    RST = 1'b1;
    @(posedge CLK); #1;
    run_pkt(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
